// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
//   Shares one frame-buffer BRAM port between a buffered NTSC pixel writer, a
//   real-time VGA pixel reader and a frame-clear sequencer.
//   Slot priority per cycle: forced write > read > clear word > FIFO write > idle.
//   A forced write happens after MAX_READ_BURST read grants made while the FIFO
//   was non-empty, so the writer is never starved.
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   wr_req/wr_addr/wr_data    write request into the FIFO (accepted with wr_ready)
//   wr_ready, wr_level        FIFO not full, FIFO occupancy
//   rd_req/rd_addr            read request (accepted with rd_ready)
//   rd_ready                  read may be granted this cycle
//   rd_valid, rd_data         read result, three cycles after acceptance
//   clear_start, clear_busy   start / progress of the clear sequence
//   bram_addr/din/we          registered BRAM port controls
//   bram_dout                 BRAM read data, one cycle after the address
module bram_port_arbiter #(
  parameter int unsigned       ADDR_W         = 14,
  parameter int unsigned       DATA_W         = 36,
  parameter int unsigned       DEPTH          = 16384,
  parameter int unsigned       FIFO_DEPTH     = 4,
  parameter int unsigned       MAX_READ_BURST = 8,
  parameter logic [DATA_W-1:0] CLEAR_VALUE    = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic [2:0]        wr_level,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_din,
  output logic              bram_we,
  input  logic [DATA_W-1:0] bram_dout
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned BURST_W = $clog2(MAX_READ_BURST + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   clear_cnt;

  logic [ADDR_W-1:0]   fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic [LVL_W-1:0]    level;

  logic [BURST_W-1:0]  burst_cnt;
  logic [1:0]          rd_pipe;

  logic fifo_empty;
  logic fifo_full;
  logic forced_write;
  logic push;
  logic rd_grant;
  logic clear_grant;
  logic fifo_grant;

  always_comb begin
    fifo_empty   = (level == '0);
    fifo_full    = (level == LVL_W'(FIFO_DEPTH));
    forced_write = (burst_cnt == BURST_W'(MAX_READ_BURST)) && !fifo_empty;
    rd_ready     = !forced_write;
    wr_ready     = !fifo_full;
    wr_level     = 3'(level);
    push         = wr_req && wr_ready;
    rd_grant     = rd_req && !forced_write;
    clear_grant  = !forced_write && !rd_req && (state == CLEAR);
    // FIFO drains either through a forced slot or through a slot nobody else wants
    fifo_grant   = forced_write || (!rd_req && (state != CLEAR) && !fifo_empty);
  end

  // FIFO storage needs no reset: occupancy is tracked by level/pointers
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr] <= wr_addr;
      fifo_data[wptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push)       wptr <= wptr + PTR_W'(1);
      if (fifo_grant) rptr <= rptr + PTR_W'(1);
      case ({push, fifo_grant})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Burst limiter: only reads granted while a write is waiting count
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_cnt <= '0;
    end else if (rd_grant) begin
      if (fifo_empty)
        burst_cnt <= '0;
      else if (burst_cnt != BURST_W'(MAX_READ_BURST))
        burst_cnt <= burst_cnt + BURST_W'(1);
    end else begin
      burst_cnt <= '0;
    end
  end

  // Clear sequencer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clear_cnt  <= '0;
      clear_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_start) begin
            state      <= CLEAR;
            clear_cnt  <= '0;
            clear_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (clear_grant) begin
            if (clear_cnt == ADDR_W'(DEPTH - 1)) begin
              state      <= IDLE;
              clear_busy <= 1'b0;
            end
            clear_cnt <= clear_cnt + ADDR_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // BRAM port drive; the grants are mutually exclusive
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bram_addr <= '0;
      bram_din  <= '0;
      bram_we   <= 1'b0;
    end else begin
      bram_we <= 1'b0;
      if (fifo_grant) begin
        bram_addr <= fifo_addr[rptr];
        bram_din  <= fifo_data[rptr];
        bram_we   <= 1'b1;
      end else if (rd_grant) begin
        bram_addr <= rd_addr;
      end else if (clear_grant) begin
        bram_addr <= clear_cnt;
        bram_din  <= CLEAR_VALUE;
        bram_we   <= 1'b1;
      end
    end
  end

  // Read return: address out at N+1, BRAM data at N+2, registered at N+3
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pipe  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_pipe  <= {rd_pipe[0], rd_grant};
      rd_valid <= rd_pipe[1];
      if (rd_pipe[1]) rd_data <= bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
module tb_bram_port_arbiter;

  localparam int unsigned ADDR_W = 14;
  localparam int unsigned DATA_W = 36;
  localparam int unsigned DEPTH  = 16384;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              wr_req = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic [2:0]        wr_level;
  logic              rd_req = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              clear_start = 1'b0;
  logic              clear_busy;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_din;
  logic              bram_we;
  logic [DATA_W-1:0] bram_dout = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t               wq[$];
  logic [DATA_W-1:0] rq[$];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned busy_falls = 0;
  logic        prev_busy = 1'b0;

  always #5 clk = ~clk;

  bram_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .FIFO_DEPTH(4),
    .MAX_READ_BURST(8),
    .CLEAR_VALUE(36'h0)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .wr_req(wr_req),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_ready(wr_ready),
    .wr_level(wr_level),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_ready(rd_ready),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .clear_start(clear_start),
    .clear_busy(clear_busy),
    .bram_addr(bram_addr),
    .bram_din(bram_din),
    .bram_we(bram_we),
    .bram_dout(bram_dout)
  );

  // Read-only BRAM model with one cycle of latency and address-derived contents
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    if (a == 14'd5) return 36'hABC;
    return {a, 8'h5A, ~a};
  endfunction

  always @(posedge clk) bram_dout <= pattern(bram_addr);

  // Scoreboard monitor: every BRAM write and every read result is matched in order
  always @(negedge clk) begin
    wr_t               ew;
    logic [DATA_W-1:0] er;
    if (!reset_n) begin
      prev_busy = 1'b0;
    end else begin
      if (prev_busy && !clear_busy) busy_falls++;
      prev_busy = clear_busy;
      if (bram_we) begin
        n_checks++;
        if (wq.size() == 0) begin
          n_fail++;
          $display("FAIL bram_write: unexpected write addr=%h data=%h, required no write", bram_addr, bram_din);
        end else begin
          ew = wq.pop_front();
          if (bram_addr !== ew.addr || bram_din !== ew.data) begin
            n_fail++;
            $display("FAIL bram_write: got addr=%h data=%h, required addr=%h data=%h",
                     bram_addr, bram_din, ew.addr, ew.data);
          end
        end
      end
      if (rd_valid) begin
        n_checks++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL rd_result: unexpected rd_valid data=%h, required no result", rd_data);
        end else begin
          er = rq.pop_front();
          if (rd_data !== er) begin
            n_fail++;
            $display("FAIL rd_result: got %h, required %h", rd_data, er);
          end
        end
      end
    end
  end

  task automatic wait_drain(input int unsigned budget);
    int unsigned c = 0;
    while ((wq.size() != 0 || rq.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic push_clears();
    wr_t e;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      e.addr = ADDR_W'(i);
      e.data = '0;
      wq.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bram_we !== 1'b0 || rd_valid !== 1'b0 || clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: we=%b rd_valid=%b busy=%b, required 0 0 0", bram_we, rd_valid, clear_busy);
    end
    n_checks++;
    if (wr_ready !== 1'b1 || wr_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_fifo: wr_ready=%b level=%0d, required 1 0", wr_ready, wr_level);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bram_we !== 1'b0 || rd_valid !== 1'b0 || bram_addr !== '0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: we=%b rd_valid=%b addr=%h rd_data=%h, required 0 0 0 0",
               bram_we, rd_valid, bram_addr, rd_data);
    end
    n_checks++;
    if (wr_ready !== 1'b1 || wr_level !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle_fifo: wr_ready=%b level=%0d, required 1 0", wr_ready, wr_level);
    end
  endtask

  task automatic test_single_read();
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = 14'h0005;
    #1;
    n_checks++;
    if (rd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL single_read_ready: got %b, required 1", rd_ready);
    end
    rq.push_back(36'hABC);
    @(posedge clk);
    #1;
    rd_req = 1'b0;
    n_checks++;
    if (bram_addr !== 14'h0005 || bram_we !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_addr: addr=%h we=%b, required 0005 0", bram_addr, bram_we);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_early: rd_valid=%b at N+2, required 0", rd_valid);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_valid !== 1'b1 || rd_data !== 36'hABC) begin
      n_fail++;
      $display("FAIL single_read_data: rd_valid=%b data=%h at N+3, required 1 abc", rd_valid, rd_data);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_read_pulse: rd_valid=%b at N+4, required 0", rd_valid);
    end
    wait_drain(20);
    n_checks++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL single_read_drain: pending=%0d, required 0", rq.size());
    end
  endtask

  task automatic test_back_to_back();
    int first = -1;
    int last = -1;
    int pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (first < 0) first = i;
        last = i;
        pulses++;
      end
      rd_req  = (i < 6);
      rd_addr = ADDR_W'($urandom);
      #1;
      if (i < 6) begin
        n_checks++;
        if (rd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: cycle %0d rd_ready=%b, required 1", i, rd_ready);
        end else begin
          rq.push_back(pattern(rd_addr));
        end
      end
    end
    rd_req = 1'b0;
    n_checks++;
    if (pulses != 6 || first != 3 || last != 8) begin
      n_fail++;
      $display("FAIL b2b_timing: pulses=%0d first=%0d last=%0d, required 6 3 8", pulses, first, last);
    end
    wait_drain(20);
    n_checks++;
    if (rq.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain: pending=%0d, required 0", rq.size());
    end
  endtask

  task automatic test_forced_write();
    int forced_cyc = -1;
    int forced_seen = 0;
    wr_t e;
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      rd_req  = 1'b1;
      rd_addr = ADDR_W'($urandom);
      wr_req  = (i == 2);
      wr_addr = 14'h1234;
      wr_data = 36'h9_8765_4321;
      #1;
      if (rd_ready === 1'b1) begin
        rq.push_back(pattern(rd_addr));
      end else begin
        forced_seen++;
        forced_cyc = i;
      end
      if (wr_req && wr_ready === 1'b1) begin
        e.addr = wr_addr;
        e.data = wr_data;
        wq.push_back(e);
      end
      if (i == 3) begin
        n_checks++;
        if (wr_level !== 3'd1) begin
          n_fail++;
          $display("FAIL forced_level: got %0d, required 1", wr_level);
        end
      end
      @(negedge clk);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    n_checks++;
    if (forced_seen != 1 || forced_cyc != 11) begin
      n_fail++;
      $display("FAIL forced_slot: stalls=%0d at cycle %0d, required 1 at cycle 11", forced_seen, forced_cyc);
    end
    wait_drain(20);
    n_checks++;
    if (wq.size() != 0 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL forced_drain: writes=%0d reads=%0d, required 0 0", wq.size(), rq.size());
    end
  endtask

  task automatic test_fifo_full();
    wr_t e;
    wr_t ent[5];
    int unsigned cyc = 0;
    for (int k = 0; k < 5; k++) begin
      ent[k].addr = ADDR_W'(14'h2000 + 14'(k * 37));
      ent[k].data = {4'($urandom), 32'($urandom)};
    end
    @(negedge clk);
    clear_start = 1'b1;
    push_clears();
    @(negedge clk);
    clear_start = 1'b0;
    n_checks++;
    if (clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_clear_busy: got %b, required 1", clear_busy);
    end
    for (int k = 0; k < 4; k++) begin
      wr_req  = 1'b1;
      wr_addr = ent[k].addr;
      wr_data = ent[k].data;
      #1;
      n_checks++;
      if (wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL full_accept: entry %0d wr_ready=%b, required 1", k, wr_ready);
      end else begin
        wq.push_back(ent[k]);
      end
      @(negedge clk);
    end
    wr_addr = ent[4].addr;
    wr_data = ent[4].data;
    #1;
    n_checks++;
    if (wr_ready !== 1'b0 || wr_level !== 3'd4) begin
      n_fail++;
      $display("FAIL full_stall: wr_ready=%b level=%0d, required 0 4", wr_ready, wr_level);
    end
    while (wr_ready !== 1'b1 && cyc < DEPTH + 50) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    n_checks++;
    if (wr_ready !== 1'b1 || cyc != DEPTH - 3) begin
      n_fail++;
      $display("FAIL full_release: wr_ready=%b after %0d cycles, required 1 after %0d", wr_ready, cyc, DEPTH - 3);
    end
    if (wr_ready === 1'b1) begin
      e = ent[4];
      wq.push_back(e);
    end
    @(negedge clk);
    wr_req = 1'b0;
    wait_drain(50);
    n_checks++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: pending writes=%0d, required 0", wq.size());
    end
  endtask

  task automatic test_clear();
    int unsigned falls0 = busy_falls;
    int unsigned cyc = 0;
    @(negedge clk);
    clear_start = 1'b1;
    push_clears();
    @(negedge clk);
    clear_start = 1'b0;
    n_checks++;
    if (clear_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_busy_rise: got %b, required 1", clear_busy);
    end
    repeat (50) @(negedge clk);
    clear_start = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    while (clear_busy === 1'b1 && cyc < DEPTH + 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_end: clear_busy=%b after %0d cycles, required 0", clear_busy, cyc);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (busy_falls - falls0 != 1 || clear_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_once: falls=%0d busy=%b, required 1 0", busy_falls - falls0, clear_busy);
    end
    wait_drain(50);
    n_checks++;
    if (wq.size() != 0) begin
      n_fail++;
      $display("FAIL clear_drain: pending writes=%0d, required 0", wq.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    int unsigned cyc = 0;
    @(negedge clk);
    clear_start = 1'b1;
    push_clears();
    @(negedge clk);
    clear_start = 1'b0;
    while (!(bram_we === 1'b1 && bram_addr === 14'd99) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (bram_we !== 1'b1 || bram_addr !== 14'd99) begin
      n_fail++;
      $display("FAIL midclear_reach: addr=%h we=%b, required 0063 1", bram_addr, bram_we);
    end
    rd_req  = 1'b1;
    rd_addr = 14'h0007;
    @(negedge clk);
    rd_req = 1'b0;
    #2;
    reset_n = 1'b0;
    wq.delete();
    rq.delete();
    #1;
    n_checks++;
    if (bram_we !== 1'b0 || bram_addr !== '0 || bram_din !== '0 || rd_valid !== 1'b0 || rd_data !== '0) begin
      n_fail++;
      $display("FAIL midclear_reset_bram: we=%b addr=%h din=%h rd_valid=%b rd_data=%h, required all 0",
               bram_we, bram_addr, bram_din, rd_valid, rd_data);
    end
    n_checks++;
    if (clear_busy !== 1'b0 || wr_ready !== 1'b1 || wr_level !== 3'd0) begin
      n_fail++;
      $display("FAIL midclear_reset_ctrl: busy=%b wr_ready=%b level=%0d, required 0 1 0",
               clear_busy, wr_ready, wr_level);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (rd_valid !== 1'b0 || bram_we !== 1'b0 || clear_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midclear_after: cycle %0d rd_valid=%b we=%b busy=%b, required 0 0 0",
                 i, rd_valid, bram_we, clear_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_forced_write();
    test_fifo_full();
    test_clear();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
